// File: rtl/chk_pkg.sv
// Shared types and default sizing for the counter stream checker.
package chk_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        LOCKED = 2'd2,
        LOST   = 2'd3
    } chk_state_t;

    localparam int CHK_WIDTH  = 8;
    localparam int CHK_STEP   = 1;
    localparam int CHK_LOCK_N = 4;
    localparam int CHK_CNT_W  = 16;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones once full.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_clr,
    input  logic         i_inc,
    output logic [W-1:0] o_count
);

    logic [W-1:0] r_count;
    logic         w_full;

    assign w_full  = (r_count == {W{1'b1}});
    assign o_count = r_count;

    // Count register: clear wins over increment, increment stops at full scale.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc && !w_full) begin
            r_count <= r_count + W'(1);
        end else begin
            r_count <= r_count;
        end
    end

endmodule

// File: rtl/counter_stream_checker.sv
// Receive-side lock/track checker for an incrementing counter stream.
// Optional first-mismatch capture ports are enabled by defining CHK_CAPTURE_EN.
module counter_stream_checker
    import chk_pkg::*;
#(
    parameter int Width  = CHK_WIDTH,
    parameter int STEP   = CHK_STEP,
    parameter int LOCK_N = CHK_LOCK_N,
    parameter int CNT_W  = CHK_CNT_W
) (
    input  logic             clk_p,
    input  logic             rst_n,
    input  logic [Width-1:0] data_in,
    input  logic             data_valid,
    input  logic             clear,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] match_count,
    output logic [1:0]       state
`ifdef CHK_CAPTURE_EN
    ,
    output logic [Width-1:0] first_exp,
    output logic [Width-1:0] first_act,
    output logic             cap_valid
`endif
);

    localparam int                RUN_W    = $clog2(LOCK_N + 1);
    localparam logic [RUN_W-1:0]  RUN_LOCK = RUN_W'(LOCK_N);
    localparam logic [Width-1:0]  STEP_W   = Width'(STEP);
    localparam chk_state_t        ST_ON_LOSS  = (LOCK_N == 1) ? LOCKED : LOST;
    localparam chk_state_t        ST_ON_FIRST = (LOCK_N == 1) ? LOCKED : SEARCH;

    chk_state_t       r_state, w_state_nxt;
    logic [Width-1:0] r_exp, w_exp_nxt;
    logic [RUN_W-1:0] r_run, w_run_nxt;
    logic             r_locked;
    logic             r_err_pulse, w_err_pulse_nxt;
    logic             w_inc_match, w_inc_err;
    logic             w_match;
    logic [Width-1:0] w_resync_exp;
    logic [RUN_W-1:0] w_run_inc;

    assign w_match      = (data_in == r_exp);
    assign w_resync_exp = data_in + STEP_W;
    assign w_run_inc    = r_run + RUN_W'(1);

    // Next-state, tracking registers and counter strobes.
    always_comb begin
        w_state_nxt     = r_state;
        w_exp_nxt       = r_exp;
        w_run_nxt       = r_run;
        w_err_pulse_nxt = 1'b0;
        w_inc_match     = 1'b0;
        w_inc_err       = 1'b0;
        if (clear) begin
            w_state_nxt = IDLE;
            w_exp_nxt   = '0;
            w_run_nxt   = '0;
        end else if (data_valid) begin
            case (r_state)
                IDLE: begin
                    w_exp_nxt   = w_resync_exp;
                    w_run_nxt   = RUN_W'(1);
                    w_state_nxt = ST_ON_FIRST;
                end
                SEARCH, LOST: begin
                    // A mismatching word seeds a fresh run of length one.
                    if (w_match) begin
                        w_exp_nxt = w_resync_exp;
                        w_run_nxt = w_run_inc;
                        if (w_run_inc == RUN_LOCK) begin
                            w_state_nxt = LOCKED;
                        end else begin
                            w_state_nxt = r_state;
                        end
                    end else begin
                        w_exp_nxt       = w_resync_exp;
                        w_run_nxt       = RUN_W'(1);
                        w_inc_err       = (r_state == LOST);
                        w_err_pulse_nxt = (r_state == LOST);
                    end
                end
                LOCKED: begin
                    if (w_match) begin
                        w_exp_nxt   = w_resync_exp;
                        w_inc_match = 1'b1;
                    end else begin
                        w_exp_nxt       = w_resync_exp;
                        w_run_nxt       = RUN_W'(1);
                        w_inc_err       = 1'b1;
                        w_err_pulse_nxt = 1'b1;
                        w_state_nxt     = ST_ON_LOSS;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end else begin
            w_state_nxt = r_state;
        end
    end

    // State, tracking and registered status outputs.
    always_ff @(posedge clk_p or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_exp       <= '0;
            r_run       <= '0;
            r_locked    <= 1'b0;
            r_err_pulse <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_exp       <= w_exp_nxt;
            r_run       <= w_run_nxt;
            r_locked    <= (w_state_nxt == LOCKED);
            r_err_pulse <= w_err_pulse_nxt;
        end
    end

    sat_counter #(.W(CNT_W)) u_match_cnt (
        .i_clk   (clk_p),
        .i_rst_n (rst_n),
        .i_clr   (clear),
        .i_inc   (w_inc_match),
        .o_count (match_count)
    );

    sat_counter #(.W(CNT_W)) u_err_cnt (
        .i_clk   (clk_p),
        .i_rst_n (rst_n),
        .i_clr   (clear),
        .i_inc   (w_inc_err),
        .o_count (err_count)
    );

    assign locked    = r_locked;
    assign err_pulse = r_err_pulse;
    assign state     = r_state;

`ifdef CHK_CAPTURE_EN
    logic [Width-1:0] r_first_exp, r_first_act;
    logic             r_cap_valid;

    // Latch only the first counted mismatch since reset or clear.
    always_ff @(posedge clk_p or negedge rst_n) begin
        if (!rst_n) begin
            r_first_exp <= '0;
            r_first_act <= '0;
            r_cap_valid <= 1'b0;
        end else if (clear) begin
            r_first_exp <= '0;
            r_first_act <= '0;
            r_cap_valid <= 1'b0;
        end else if (w_inc_err && !r_cap_valid) begin
            r_first_exp <= r_exp;
            r_first_act <= data_in;
            r_cap_valid <= 1'b1;
        end else begin
            r_cap_valid <= r_cap_valid;
        end
    end

    assign first_exp = r_first_exp;
    assign first_act = r_first_act;
    assign cap_valid = r_cap_valid;
`endif

endmodule
